// File: rtl/muldiv_seq_if.sv
// Bus between the EX stage and the multiply/divide sequencer: operation
// request, HI/LO move strobes, HI/LO read port and busy/stall/done status.
interface muldiv_seq_if #(
    parameter int unsigned DW = 32
);
    logic          start_i;
    logic [1:0]    op_i;
    logic [DW-1:0] data1_i;
    logic [DW-1:0] data2_i;
    logic          kill_i;
    logic          wr_hi_i;
    logic          wr_lo_i;
    logic [DW-1:0] wr_data_i;
    logic          rd_sel_i;
    logic [DW-1:0] rd_data_o;
    logic          busy_o;
    logic          stall_o;
    logic          done_o;

    modport master (
        output start_i, op_i, data1_i, data2_i, kill_i,
               wr_hi_i, wr_lo_i, wr_data_i, rd_sel_i,
        input  rd_data_o, busy_o, stall_o, done_o
    );

    modport slave (
        input  start_i, op_i, data1_i, data2_i, kill_i,
               wr_hi_i, wr_lo_i, wr_data_i, rd_sel_i,
        output rd_data_o, busy_o, stall_o, done_o
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO: one shift-add or
// restoring-subtract step per cycle, with stall, flush and MTHI/MTLO support.
module muldiv_seq #(
    parameter int unsigned DW = 32,
    parameter int unsigned CW = 6
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_seq_if.slave   bus
);

    localparam int unsigned AW = 2 * DW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          is_div_q, is_div_d;
    logic          is_sgn_q, is_sgn_d;
    logic          negp_q, negp_d;
    logic          negr_q, negr_d;
    logic [DW-1:0] opa_q, opa_d;
    logic [DW-1:0] opb_q, opb_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [DW-1:0] hi_q, hi_d;
    logic [DW-1:0] lo_q, lo_d;
    logic          done_q, done_d;

    logic          accept_c;
    logic [DW-1:0] opa_abs_c;
    logic [DW-1:0] opb_abs_c;
    logic [DW:0]   mul_sum_c;
    logic [DW+1:0] div_trial_c;
    logic          div_ge_c;
    logic [AW-1:0] prod_c;
    logic [DW-1:0] quot_c;
    logic [DW-1:0] rem_c;

    assign accept_c = (state_q == S_IDLE) && bus.start_i && !done_q && !bus.kill_i;

    assign opa_abs_c = (is_sgn_q && opa_q[DW-1]) ? -opa_q : opa_q;
    assign opb_abs_c = (is_sgn_q && opb_q[DW-1]) ? -opb_q : opb_q;

    // Multiply step: add multiplicand into the upper half, carry kept for the shift.
    assign mul_sum_c = {1'b0, acc_q[AW-1:DW]} + (opb_q[0] ? {1'b0, opa_q} : (DW+1)'(0));

    // Divide step: shifted remainder needs DW+1 bits, one more for the borrow.
    assign div_trial_c = {1'b0, acc_q[AW-1:DW-1]} - {2'b00, opb_q};
    assign div_ge_c    = ~div_trial_c[DW+1];

    assign prod_c = negp_q ? -acc_q : acc_q;
    assign quot_c = negp_q ? -acc_q[DW-1:0] : acc_q[DW-1:0];
    assign rem_c  = negr_q ? -acc_q[AW-1:DW] : acc_q[AW-1:DW];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        is_sgn_d = is_sgn_q;
        negp_d   = negp_q;
        negr_d   = negr_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        if (state_q != S_IDLE && bus.kill_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        state_d  = S_PREP;
                        opa_d    = bus.data1_i;
                        opb_d    = bus.data2_i;
                        is_div_d = bus.op_i[1];
                        is_sgn_d = ~bus.op_i[0];
                        negp_d   = ~bus.op_i[0] & (bus.data1_i[DW-1] ^ bus.data2_i[DW-1]);
                        negr_d   = ~bus.op_i[0] & bus.data1_i[DW-1];
                    end else begin
                        if (bus.wr_hi_i) hi_d = bus.wr_data_i;
                        if (bus.wr_lo_i) lo_d = bus.wr_data_i;
                    end
                end
                S_PREP: begin
                    // Divide keeps the raw dividend in opa for the divide-by-zero HI value.
                    opa_d   = is_div_q ? opa_q : opa_abs_c;
                    opb_d   = opb_abs_c;
                    acc_d   = is_div_q ? {DW'(0), opa_abs_c} : AW'(0);
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
                S_RUN: begin
                    if (is_div_q) begin
                        acc_d = {(div_ge_c ? div_trial_c[DW-1:0] : acc_q[AW-2:DW-1]),
                                 acc_q[DW-2:0], div_ge_c};
                    end else begin
                        acc_d = {mul_sum_c, acc_q[DW-1:1]};
                        opb_d = opb_q >> 1;
                    end
                    if (cnt_q == CW'(DW - 1)) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_FIX: begin
                    if (!is_div_q) begin
                        {hi_d, lo_d} = prod_c;
                    end else if (opb_q == '0) begin
                        lo_d = '1;
                        hi_d = opa_q;
                    end else begin
                        lo_d = quot_c;
                        hi_d = rem_c;
                    end
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            is_sgn_q <= 1'b0;
            negp_q   <= 1'b0;
            negr_q   <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            is_sgn_q <= is_sgn_d;
            negp_q   <= negp_d;
            negr_q   <= negr_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    // Stall drops in the done cycle so the waiting instruction advances once.
    assign bus.busy_o    = (state_q != S_IDLE);
    assign bus.stall_o   = bus.busy_o | (bus.start_i & ~done_q);
    assign bus.done_o    = done_q;
    assign bus.rd_data_o = bus.rd_sel_i ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: vector table through a result
// scoreboard, plus hand-written kill, reset, held-start and MTHI sequences.
module tb_muldiv_seq;

    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_seq_if #(.DW(DW)) bus ();

    muldiv_seq #(.DW(DW), .CW(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    vec_t        vecs[$];
    res_t        sb[$];
    int          total  = 0;
    int          passed = 0;
    logic [31:0] hi_m   = '0;
    logic [31:0] lo_m   = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic add_vec(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] hi, input logic [31:0] lo);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo;
        vecs.push_back(v);
    endtask

    task automatic read_hi(output logic [31:0] v);
        bus.rd_sel_i = 1'b1; #1;
        v = bus.rd_data_o;
        bus.rd_sel_i = 1'b0; #1;
    endtask

    // Counts done pulses and busy cycles over a window of idle cycles.
    task automatic quiet_window(input string nm, input int cycles);
        int d = 0;
        int b = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done_o) d++;
            if (bus.busy_o) b++;
        end
        chk({nm, "_no_done"}, 64'(d), 64'(0));
        chk({nm, "_no_busy"}, 64'(b), 64'(0));
    endtask

    task automatic run_op(input vec_t v, input int idx);
        res_t        r;
        res_t        got;
        int          n;
        int          stall_n;
        logic [31:0] h;
        @(negedge clk);
        bus.op_i     = v.op;
        bus.data1_i  = v.a;
        bus.data2_i  = v.b;
        bus.start_i  = 1'b1;
        bus.rd_sel_i = 1'b0;
        r.hi = v.hi;
        r.lo = v.lo;
        sb.push_back(r);
        @(negedge clk);
        bus.start_i = 1'b0;
        n       = 1;
        stall_n = 0;
        while (n < 200 && !bus.done_o) begin
            if (bus.stall_o) stall_n++;
            if (n == 10) chk($sformatf("v%0d_run_read_lo", idx), 64'(bus.rd_data_o), 64'(lo_m));
            @(negedge clk);
            n++;
        end
        chk($sformatf("v%0d_latency", idx), 64'(n), 64'(DW + 3));
        chk($sformatf("v%0d_stall_cycles", idx), 64'(stall_n), 64'(DW + 2));
        chk($sformatf("v%0d_stall_in_done", idx), 64'(bus.stall_o), 64'(0));
        got = sb.pop_front();
        read_hi(h);
        chk($sformatf("v%0d_hi", idx), 64'(h), 64'(got.hi));
        chk($sformatf("v%0d_lo", idx), 64'(bus.rd_data_o), 64'(got.lo));
        hi_m = got.hi;
        lo_m = got.lo;
        @(negedge clk);
        chk($sformatf("v%0d_done_pulse", idx), 64'(bus.done_o), 64'(0));
    endtask

    initial begin
        logic [31:0] h;
        int          n;
        int          dcnt;

        rst           = 1'b1;
        bus.start_i   = 1'b0;
        bus.op_i      = 2'b00;
        bus.data1_i   = '0;
        bus.data2_i   = '0;
        bus.kill_i    = 1'b0;
        bus.wr_hi_i   = 1'b0;
        bus.wr_lo_i   = 1'b0;
        bus.wr_data_i = '0;
        bus.rd_sel_i  = 1'b0;

        add_vec(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        add_vec(2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
        add_vec(2'b01, 32'hFFFF_FFFD, 32'd7,         32'h0000_0006, 32'hFFFF_FFEB);
        add_vec(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        add_vec(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
        add_vec(2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        add_vec(2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        add_vec(2'b11, 32'd100,       32'd7,         32'd2,         32'd14);
        add_vec(2'b11, 32'h64,        32'd0,         32'h64,        32'hFFFF_FFFF);
        add_vec(2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
        add_vec(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        add_vec(2'b11, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(bus.busy_o), 64'(0));
        chk("rst_done", 64'(bus.done_o), 64'(0));
        chk("rst_stall", 64'(bus.stall_o), 64'(0));
        chk("rst_lo", 64'(bus.rd_data_o), 64'(0));
        read_hi(h);
        chk("rst_hi", 64'(h), 64'(0));

        for (int i = 0; i < vecs.size(); i++) run_op(vecs[i], i);

        // MTLO then a MULT flushed at cycle 10.
        @(negedge clk);
        bus.wr_lo_i = 1'b1; bus.wr_data_i = 32'h1234;
        @(negedge clk);
        bus.wr_lo_i = 1'b0;
        lo_m = 32'h1234;
        chk("mtlo_lo", 64'(bus.rd_data_o), 64'(lo_m));
        bus.op_i = 2'b00; bus.data1_i = 32'd2; bus.data2_i = 32'd3; bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (9) @(negedge clk);
        chk("kill_busy_before", 64'(bus.busy_o), 64'(1));
        bus.kill_i = 1'b1;
        @(negedge clk);
        bus.kill_i = 1'b0;
        chk("kill_busy_after", 64'(bus.busy_o), 64'(0));
        chk("kill_lo_kept", 64'(bus.rd_data_o), 64'(lo_m));
        quiet_window("kill", 40);
        chk("kill_lo_final", 64'(bus.rd_data_o), 64'(lo_m));

        // kill in IDLE blocks a same-cycle start.
        bus.start_i = 1'b1; bus.kill_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0; bus.kill_i = 1'b0;
        chk("idle_kill_blocks", 64'(bus.busy_o), 64'(0));

        // MTHI, then reset in the middle of a MULTU.
        bus.wr_hi_i = 1'b1; bus.wr_data_i = 32'h5555;
        @(negedge clk);
        bus.wr_hi_i = 1'b0;
        hi_m = 32'h5555;
        read_hi(h);
        chk("mthi_hi", 64'(h), 64'(hi_m));
        bus.op_i = 2'b01; bus.data1_i = 32'd9; bus.data2_i = 32'd9; bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hi_m = '0; lo_m = '0;
        chk("rst_mid_busy", 64'(bus.busy_o), 64'(0));
        chk("rst_mid_lo", 64'(bus.rd_data_o), 64'(0));
        read_hi(h);
        chk("rst_mid_hi", 64'(h), 64'(0));
        quiet_window("rst_mid", 40);

        // start held through done plus MTHI on the accepting cycle and while busy.
        bus.op_i = 2'b01; bus.data1_i = 32'd5; bus.data2_i = 32'd6; bus.start_i = 1'b1;
        bus.wr_hi_i = 1'b1; bus.wr_data_i = 32'hDEAD;
        @(negedge clk);
        bus.wr_hi_i = 1'b0;
        n = 1;
        dcnt = 0;
        while (n < 200 && !bus.done_o) begin
            if (n == 5) begin
                read_hi(h);
                chk("mthi_on_accept_dropped", 64'(h), 64'(hi_m));
                bus.wr_hi_i = 1'b1; bus.wr_data_i = 32'hBEEF;
            end
            if (n == 6) bus.wr_hi_i = 1'b0;
            if (n == 8) begin
                read_hi(h);
                chk("mthi_busy_ignored", 64'(h), 64'(hi_m));
            end
            @(negedge clk);
            n++;
        end
        chk("held_latency", 64'(n), 64'(DW + 3));
        chk("held_stall_in_done", 64'(bus.stall_o), 64'(0));
        read_hi(h);
        chk("held_hi", 64'(h), 64'(0));
        chk("held_lo", 64'(bus.rd_data_o), 64'(30));
        @(negedge clk);
        bus.start_i = 1'b0;
        quiet_window("held_one_op", 40);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", passed, total);
        $fatal(1);
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer that owns the HI/LO register pair and feeds results back to the EX stage.
- Implements MULT, MULTU, DIV and DIVU with one shift-add or restoring-subtract step per cycle.
- Holds the pipeline through a stall output while busy; services MFHI/MFLO reads and MTHI/MTLO writes.
- EX-stage operand forwarding and the hazard unit remain outside this block.

Parameters:
DW, 32, operand width; HI and LO are DW bits each
CW, 6, iteration counter width; must satisfy 2^CW > DW

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start_i  in  1  mult/div instruction present in EX
op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
data1_i  in  DW  multiplicand / dividend (rs)
data2_i  in  DW  multiplier / divisor (rt)
kill_i  in  1  abort the operation in flight (flush)
wr_hi_i  in  1  MTHI strobe
wr_lo_i  in  1  MTLO strobe
wr_data_i  in  DW  MTHI/MTLO data
rd_sel_i  in  1  0 = read LO, 1 = read HI
rd_data_o  out  DW  combinational HI or LO per rd_sel_i
busy_o  out  1  state != IDLE
stall_o  out  1  hold IF..EX
done_o  out  1  one-cycle registered completion pulse

Behaviour:
- Reset: state IDLE, counter 0, HI = LO = 0, done_o = 0, busy_o = 0. Reset overrides every other input, including mid-operation; no partial result is written.
- Accept condition: state IDLE and start_i and !done_o. On the accepting edge, latch op, operands and sign flags, then go to PREP.
- PREP, 1 cycle:
  - Signed ops: replace each operand with its absolute value. Quotient/product negate flag = sign1 XOR sign2. Remainder negate flag = sign1.
  - Unsigned ops: no negation.
  - Clear the 2*DW accumulator, counter = 0, go to RUN.
- RUN, exactly DW cycles, one iteration per edge:
  - Multiply: if multiplier LSB is 1, add the multiplicand into the upper half; shift the accumulator right by 1.
  - Divide: shift {rem, quot} left by 1; trial-subtract the divisor from rem; if the result is non-negative, keep it and set quot LSB.
  - When counter == DW-1, go to FIX.
- FIX, 1 cycle:
  - Apply the negate flags.
  - Write HI/LO: mult gives {HI,LO} = 2*DW product; div gives LO = quotient, HI = remainder.
  - Set done_o = 1 and go to IDLE.
- Latency: HI/LO hold new values and done_o = 1 in the cycle after the (DW+2)th edge following acceptance, i.e. 34 cycles after acceptance for DW = 32.
- stall_o = busy_o | (start_i & !done_o). It is low in the done_o cycle, so the stalled instruction advances and is not restarted.
- Divide by zero: LO = all ones, HI = data1 (raw dividend, both signed and unsigned); no trap.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): LO = 0x80000000, HI = 0.
- kill_i: in any non-IDLE state, the next edge goes to IDLE; HI/LO unchanged; done_o stays 0. In IDLE, kill_i blocks a same-cycle start.
- MTHI/MTLO: take effect only in IDLE with no accepted start. If start_i is accepted in the same cycle, the write is dropped. While busy, writes are ignored.
- Reads: combinational from the HI/LO registers. Reads during RUN return the pre-operation values.
- Back-to-back: a new start is accepted no earlier than the cycle after the done_o cycle.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 34 cycles HI=0xFFFFFFFE, LO=0x00000001, done_o pulses exactly 1 cycle, stall_o high cycles 0..33.
- MULT 0xFFFFFFFD (-3) x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; then MULTU with the same operands -> HI=0x00000006, LO=0xFFFFFFEB.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100 / 7 -> LO=14, HI=2.
- DIVU 0x64 / 0 -> LO=0xFFFFFFFF, HI=0x64; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTLO 0x1234 then MULT 2x3 with kill_i at cycle 10 -> LO stays 0x1234, busy_o low next cycle, no done_o; rst at cycle 20 of a second op -> HI=LO=0, IDLE.
- start_i held high through done_o -> exactly one operation per instruction; MTHI asserted with an accepted start -> HI write dropped.
